// File: rtl/sample_packer_pkg.sv
// Shared widths, FSM state encoding and the flush padding helper for sample_packer.
package sample_packer_pkg;
    localparam int SAMPLE_W = 12;
    localparam int WORD_W   = 36;
    localparam int ADDR_W   = 19;
    localparam int SLOTS    = 3;

    typedef enum logic [2:0] {
        IDLE,
        REC,
        WR,
        PLAY,
        RD_ISSUE,
        RD_WAIT,
        FLUSH
    } state_t;

    // Zero every slot at or beyond the fill count so a partial word flushes clean.
    function automatic logic [WORD_W-1:0] pad_word(input logic [WORD_W-1:0] word,
                                                   input logic [1:0] filled);
        logic [WORD_W-1:0] result;
        result = word;
        if (filled < 2'd3) result[SAMPLE_W-1:0] = '0;
        if (filled < 2'd2) result[2*SAMPLE_W-1:SAMPLE_W] = '0;
        if (filled < 2'd1) result[WORD_W-1:2*SAMPLE_W] = '0;
        return result;
    endfunction
endpackage

// File: rtl/sample_packer_slot_shifter.sv
// Three-slot sample register: packs recorded samples into a word, or unpacks a read word by slot.
module sample_packer_slot_shifter
    import sample_packer_pkg::*;
(
    input  logic                clk,
    input  logic                reset,
    input  logic                store,
    input  logic [1:0]          slot,
    input  logic [SAMPLE_W-1:0] sample_in,
    input  logic                load,
    input  logic [WORD_W-1:0]   word_in,
    output logic [WORD_W-1:0]   word,
    output logic [SAMPLE_W-1:0] sample_sel
);
    logic [SAMPLE_W-1:0] slot0;
    logic [SAMPLE_W-1:0] slot1;
    logic [SAMPLE_W-1:0] slot2;

    // A full-word load from memory takes priority over a single-slot store.
    always_ff @(posedge clk) begin
        if (reset) begin
            slot0 <= '0;
            slot1 <= '0;
            slot2 <= '0;
        end else if (load) begin
            slot0 <= word_in[WORD_W-1 -: SAMPLE_W];
            slot1 <= word_in[2*SAMPLE_W-1 -: SAMPLE_W];
            slot2 <= word_in[SAMPLE_W-1:0];
        end else if (store) begin
            case (slot)
                2'd0:    slot0 <= sample_in;
                2'd1:    slot1 <= sample_in;
                2'd2:    slot2 <= sample_in;
                default: ;
            endcase
        end
    end

    assign word = {slot0, slot1, slot2};

    always_comb begin
        case (slot)
            2'd1:    sample_sel = slot1;
            2'd2:    sample_sel = slot2;
            default: sample_sel = slot0;
        endcase
    end
endmodule

// File: rtl/sample_packer.sv
// Packs three 12-bit audio samples per 36-bit ZBT word for record, and unpacks them for playback.
module sample_packer
    import sample_packer_pkg::*;
#(
    parameter int RD_LAT = 2
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                ready,
    input  logic                start_song,
    input  logic                pause_song,
    input  logic                record_mode,
    input  logic                song_done,
    input  logic [ADDR_W-1:0]   mem_address,
    input  logic [SAMPLE_W-1:0] sample_in,
    output logic [SAMPLE_W-1:0] sample_out,
    output logic [ADDR_W-1:0]   ram_addr,
    output logic                ram_we,
    output logic [WORD_W-1:0]   ram_wdata,
    input  logic [WORD_W-1:0]   ram_rdata,
    output logic                busy
);
    state_t              state;
    state_t              state_next;
    logic [1:0]          slot;
    logic                record_q;
    logic [ADDR_W-1:0]   word_addr;
    logic [ADDR_W-1:0]   ram_addr_hold;
    logic [7:0]          wait_cnt;
    logic                load_pending;
    logic [SAMPLE_W-1:0] sample_hold;
    logic                accepted;
    logic                wait_done;
    logic                capture;
    logic                store;
    logic [WORD_W-1:0]   word;
    logic [SAMPLE_W-1:0] sample_sel;

    assign accepted  = ready & ~pause_song & ~song_done & ~start_song &
                       ((state == REC) | (state == PLAY));
    assign wait_done = (wait_cnt == 8'(RD_LAT - 1));
    assign capture   = (state == RD_WAIT) & wait_done & ~song_done & ~start_song;
    assign store     = accepted & record_q;

    sample_packer_slot_shifter u_shifter (
        .clk        (clk),
        .reset      (reset),
        .store      (store),
        .slot       (slot),
        .sample_in  (sample_in),
        .load       (capture),
        .word_in    (ram_rdata),
        .word       (word),
        .sample_sel (sample_sel)
    );

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    // start_song overrides everything, including a ready on the same edge.
    always_comb begin
        state_next = state;
        if (start_song) begin
            state_next = record_mode ? REC : PLAY;
        end else begin
            case (state)
                IDLE:     state_next = IDLE;
                REC:      if (song_done)                       state_next = (slot != 2'd0) ? FLUSH : IDLE;
                          else if (accepted && slot == 2'd2)   state_next = WR;
                WR:       state_next = REC;
                PLAY:     if (song_done)                       state_next = IDLE;
                          else if (accepted && slot == 2'd0)   state_next = RD_ISSUE;
                RD_ISSUE: state_next = song_done ? IDLE : RD_WAIT;
                RD_WAIT:  if (song_done)                       state_next = IDLE;
                          else if (wait_done)                  state_next = PLAY;
                FLUSH:    state_next = IDLE;
                default:  state_next = IDLE;
            endcase
        end
    end

    always_comb begin
        ram_we    = 1'b0;
        ram_addr  = ram_addr_hold;
        ram_wdata = '0;
        busy      = 1'b0;
        case (state)
            WR: begin
                ram_we    = 1'b1;
                ram_addr  = word_addr;
                ram_wdata = word;
                busy      = 1'b1;
            end
            FLUSH: begin
                ram_we    = 1'b1;
                ram_addr  = word_addr;
                ram_wdata = pad_word(word, slot);
                busy      = 1'b1;
            end
            RD_ISSUE: begin
                ram_addr = word_addr;
                busy     = 1'b1;
            end
            RD_WAIT: busy = 1'b1;
            default: ;
        endcase
        sample_out = (state == IDLE || state == REC || song_done) ? '0 : sample_hold;
    end

    // The address bus keeps its last driven value between memory cycles.
    always_ff @(posedge clk) begin
        if (reset) begin
            ram_addr_hold <= '0;
            slot          <= 2'd0;
            record_q      <= 1'b0;
            word_addr     <= '0;
            wait_cnt      <= 8'd0;
            load_pending  <= 1'b0;
            sample_hold   <= '0;
        end else begin
            if (state == WR || state == FLUSH || state == RD_ISSUE) ram_addr_hold <= word_addr;

            if (start_song)                slot <= 2'd0;
            else if (accepted)             slot <= (slot == 2'd2) ? 2'd0 : slot + 2'd1;
            else if (state_next == IDLE)   slot <= 2'd0;

            if (start_song) record_q <= record_mode;

            if (accepted && slot == 2'd0) word_addr <= mem_address;

            wait_cnt <= (state == RD_WAIT) ? wait_cnt + 8'd1 : 8'd0;

            if (start_song || state_next == IDLE)                 load_pending <= 1'b0;
            else if (capture)                                     load_pending <= 1'b1;
            else if (load_pending && state == PLAY && !pause_song) load_pending <= 1'b0;

            // Slot 0 appears one cycle after the word lands; slots 1 and 2 follow on ready.
            if (start_song) begin
                sample_hold <= '0;
            end else if (state == PLAY && !pause_song && !song_done) begin
                if (load_pending)                         sample_hold <= word[WORD_W-1 -: SAMPLE_W];
                else if (accepted && !record_q && slot != 2'd0) sample_hold <= sample_sel;
            end
        end
    end
endmodule

// File: tb/tb_sample_packer.sv
// Directed bench for sample_packer: table-driven record/playback words plus multi-cycle corner sequences.
module tb_sample_packer;
    logic        clk = 1'b0;
    logic        reset;
    logic        ready;
    logic        start_song;
    logic        pause_song;
    logic        record_mode;
    logic        song_done;
    logic [18:0] mem_address;
    logic [11:0] sample_in;
    logic [11:0] sample_out;
    logic [18:0] ram_addr;
    logic        ram_we;
    logic [35:0] ram_wdata;
    logic [35:0] ram_rdata;
    logic        busy;

    int n_checks = 0;
    int n_fail   = 0;
    int we_count = 0;
    logic [18:0] last_addr  = '0;
    logic [35:0] last_wdata = '0;
    logic [18:0] d1 = '0;
    logic [18:0] d2 = '0;

    typedef struct {
        logic        rec;
        logic [18:0] addr;
        logic [11:0] v0;
        logic [11:0] v1;
        logic [11:0] v2;
        logic [35:0] exp_word;
    } vec_t;

    vec_t vecs [5];

    sample_packer #(.RD_LAT(2)) dut (
        .clk         (clk),
        .reset       (reset),
        .ready       (ready),
        .start_song  (start_song),
        .pause_song  (pause_song),
        .record_mode (record_mode),
        .song_done   (song_done),
        .mem_address (mem_address),
        .sample_in   (sample_in),
        .sample_out  (sample_out),
        .ram_addr    (ram_addr),
        .ram_we      (ram_we),
        .ram_wdata   (ram_wdata),
        .ram_rdata   (ram_rdata),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    // ZBT model: data for an address appears two cycles after the address is presented.
    function automatic logic [35:0] zbt_word(input logic [18:0] a);
        case (a)
            19'd288000: return 36'hABC123456;
            19'd1000:   return 36'h000FFF7A5;
            default:    return 36'h5A5A5A5A5;
        endcase
    endfunction

    always @(posedge clk) begin
        d1 <= ram_addr;
        d2 <= d1;
    end
    assign ram_rdata = zbt_word(d2);

    always @(negedge clk) begin
        if (ram_we) begin
            we_count   = we_count + 1;
            last_addr  = ram_addr;
            last_wdata = ram_wdata;
        end
    end

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic checkOutput(input string name, input logic [35:0] act, input logic [35:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got 0x%h, expected 0x%h", name, act, exp);
        end
    endtask

    task automatic applyStimulus(input logic rec, input logic [18:0] addr);
        record_mode = rec;
        mem_address = addr;
        start_song  = 1'b1;
        tick();
        start_song  = 1'b0;
        tick();
    endtask

    task automatic send_sample(input logic [11:0] s);
        sample_in = s;
        ready     = 1'b1;
        tick();
        ready     = 1'b0;
        ticks(7);
    endtask

    task automatic end_song();
        song_done = 1'b1;
        tick();
        song_done = 1'b0;
        tick();
    endtask

    initial begin
        vecs[0] = '{1'b1, 19'd240000, 12'h111, 12'h222, 12'h333, 36'h111222333};
        vecs[1] = '{1'b1, 19'd5,      12'hABC, 12'hDEF, 12'h012, 36'hABCDEF012};
        vecs[2] = '{1'b1, 19'h7FFFF,  12'hFFF, 12'h000, 12'h800, 36'hFFF000800};
        vecs[3] = '{1'b0, 19'd288000, 12'hABC, 12'h123, 12'h456, 36'h0};
        vecs[4] = '{1'b0, 19'd1000,   12'h000, 12'hFFF, 12'h7A5, 36'h0};

        reset = 1'b1; ready = 1'b0; start_song = 1'b0; pause_song = 1'b0;
        record_mode = 1'b0; song_done = 1'b0; mem_address = '0; sample_in = '0;
        ticks(3);
        checkOutput("reset sample_out", 36'(sample_out), 36'h0);
        checkOutput("reset ram_we",     36'(ram_we),     36'h0);
        checkOutput("reset ram_addr",   36'(ram_addr),   36'h0);
        checkOutput("reset ram_wdata",  ram_wdata,       36'h0);
        checkOutput("reset busy",       36'(busy),       36'h0);
        reset = 1'b0;
        tick();

        $display("[TB] table: record and playback words");
        for (int v = 0; v < 5; v++) begin
            we_count = 0;
            applyStimulus(vecs[v].rec, vecs[v].addr);
            if (vecs[v].rec) begin
                send_sample(vecs[v].v0);
                send_sample(vecs[v].v1);
                send_sample(vecs[v].v2);
                checkOutput($sformatf("vec%0d write count", v), 36'(we_count), 36'd1);
                checkOutput($sformatf("vec%0d write addr", v), 36'(last_addr), 36'(vecs[v].addr));
                checkOutput($sformatf("vec%0d write data", v), last_wdata, vecs[v].exp_word);
                checkOutput($sformatf("vec%0d rec sample_out", v), 36'(sample_out), 36'h0);
            end else begin
                send_sample(12'h0);
                checkOutput($sformatf("vec%0d slot0 out", v), 36'(sample_out), 36'(vecs[v].v0));
                checkOutput($sformatf("vec%0d read addr", v), 36'(ram_addr), 36'(vecs[v].addr));
                send_sample(12'h0);
                checkOutput($sformatf("vec%0d slot1 out", v), 36'(sample_out), 36'(vecs[v].v1));
                send_sample(12'h0);
                checkOutput($sformatf("vec%0d slot2 out", v), 36'(sample_out), 36'(vecs[v].v2));
                checkOutput($sformatf("vec%0d no write", v), 36'(we_count), 36'd0);
            end
            end_song();
            checkOutput($sformatf("vec%0d idle busy", v), 36'(busy), 36'h0);
        end

        $display("[TB] sequence: start_song coincident with ready");
        we_count = 0;
        record_mode = 1'b1; mem_address = 19'd100; sample_in = 12'hAAA;
        start_song = 1'b1; ready = 1'b1;
        tick();
        start_song = 1'b0; ready = 1'b0;
        ticks(7);
        send_sample(12'h111);
        send_sample(12'h222);
        checkOutput("coincident no early write", 36'(we_count), 36'd0);
        send_sample(12'h333);
        checkOutput("coincident write count", 36'(we_count), 36'd1);
        checkOutput("coincident write data", last_wdata, 36'h111222333);
        end_song();
        checkOutput("coincident no flush write", 36'(we_count), 36'd1);

        $display("[TB] sequence: partial word flush");
        we_count = 0;
        applyStimulus(1'b1, 19'd77);
        send_sample(12'h7FF);
        send_sample(12'h001);
        song_done = 1'b1;
        tick();
        checkOutput("flush ram_we", 36'(ram_we), 36'd1);
        checkOutput("flush busy", 36'(busy), 36'd1);
        song_done = 1'b0;
        tick();
        checkOutput("flush write count", 36'(we_count), 36'd1);
        checkOutput("flush write addr", 36'(last_addr), 36'd77);
        checkOutput("flush write data", last_wdata, 36'h7FF001000);
        checkOutput("flush idle busy", 36'(busy), 36'd0);
        checkOutput("flush sample_out", 36'(sample_out), 36'h0);

        $display("[TB] sequence: read latency, pause, song_done in playback");
        we_count = 0;
        applyStimulus(1'b0, 19'd288000);
        ready = 1'b1;
        tick();
        ready = 1'b0;
        checkOutput("read issue addr", 36'(ram_addr), 36'd288000);
        ticks(3);
        checkOutput("before load sample_out", 36'(sample_out), 36'h0);
        tick();
        checkOutput("after load sample_out", 36'(sample_out), 36'hABC);
        ticks(6);
        pause_song = 1'b1;
        send_sample(12'h0);
        send_sample(12'h0);
        send_sample(12'h0);
        checkOutput("pause held sample_out", 36'(sample_out), 36'hABC);
        checkOutput("pause no write", 36'(we_count), 36'd0);
        checkOutput("pause no read", 36'(busy), 36'd0);
        pause_song = 1'b0;
        send_sample(12'h0);
        checkOutput("after pause slot1", 36'(sample_out), 36'h123);
        send_sample(12'h0);
        checkOutput("after pause slot2", 36'(sample_out), 36'h456);
        song_done = 1'b1;
        #1;
        checkOutput("song_done zeroes sample_out", 36'(sample_out), 36'h0);
        tick();
        song_done = 1'b0;
        tick();
        checkOutput("song_done idle busy", 36'(busy), 36'd0);

        $display("[TB] sequence: abort read in flight");
        applyStimulus(1'b0, 19'd1000);
        ready = 1'b1;
        tick();
        ready = 1'b0;
        tick();
        checkOutput("abort in read wait", 36'(busy), 36'd1);
        song_done = 1'b1;
        tick();
        song_done = 1'b0;
        checkOutput("abort idle busy", 36'(busy), 36'd0);
        ticks(4);
        checkOutput("abort sample_out", 36'(sample_out), 36'h0);

        $display("[TB] sequence: reset during write");
        we_count = 0;
        applyStimulus(1'b1, 19'd4242);
        send_sample(12'h101);
        send_sample(12'h202);
        sample_in = 12'h303;
        ready = 1'b1;
        tick();
        ready = 1'b0;
        checkOutput("write cycle ram_we", 36'(ram_we), 36'd1);
        reset = 1'b1;
        tick();
        checkOutput("reset-in-write ram_we", 36'(ram_we), 36'd0);
        checkOutput("reset-in-write ram_addr", 36'(ram_addr), 36'd0);
        checkOutput("reset-in-write ram_wdata", ram_wdata, 36'h0);
        checkOutput("reset-in-write busy", 36'(busy), 36'd0);
        checkOutput("reset-in-write sample_out", 36'(sample_out), 36'h0);
        reset = 1'b0;
        ticks(4);
        checkOutput("reset-in-write single write", 36'(we_count), 36'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
